// File: rtl/l2dr_req_arb.sv
// L2/L2TLB request arbiter into a 2-entry directory request FIFO, plus the
// reverse snack router that splits directory snacks by nid[0] (bit 0 of the payload).
module l2dr_req_arb #(
    parameter int TLB_MAX_OUT = 2,
    parameter int OUT_DEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        l2_req_valid,
    output logic        l2_req_retry,
    input  logic [31:0] l2_req,
    input  logic        tlb_req_valid,
    output logic        tlb_req_retry,
    input  logic [31:0] tlb_req,
    output logic        l2todr_req_valid,
    input  logic        l2todr_req_retry,
    output logic [31:0] l2todr_req,
    input  logic        drtol2_snack_valid,
    output logic        drtol2_snack_retry,
    input  logic [31:0] drtol2_snack,
    output logic        l2_snack_valid,
    input  logic        l2_snack_retry,
    output logic [31:0] l2_snack,
    output logic        tlb_snack_valid,
    input  logic        tlb_snack_retry,
    output logic [31:0] tlb_snack
);

    localparam logic [2:0] MAX_OUT = 3'(TLB_MAX_OUT);
    localparam logic [1:0] DEPTH   = 2'(OUT_DEPTH);

    logic [31:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        prefer_tlb_q, prefer_tlb_d;
    logic [2:0]  tlb_out_q, tlb_out_d;
    logic        l2s_v_q, l2s_v_d, tlbs_v_q, tlbs_v_d;
    logic [31:0] l2s_q, l2s_d, tlbs_q, tlbs_d;

    logic        pop, full, l2_elig, tlb_elig, gnt_l2, gnt_tlb, push;
    logic [31:0] push_data;
    logic [1:0]  wr_idx;
    logic        tlb_dec, snk_tgt, snk_acc, l2s_drain, tlbs_drain;

    always_comb begin
        pop       = (cnt_q != 2'd0) && !l2todr_req_retry;
        // A full FIFO still has room when its head leaves this cycle.
        full      = (cnt_q == DEPTH) && !pop;
        l2_elig   = l2_req_valid && !full && !reset;
        tlb_elig  = tlb_req_valid && !full && (tlb_out_q < MAX_OUT) && !reset;
        gnt_tlb   = tlb_elig && (!l2_elig || prefer_tlb_q);
        gnt_l2    = l2_elig && !gnt_tlb;
        push      = gnt_l2 || gnt_tlb;
        push_data = gnt_tlb ? tlb_req : l2_req;
        push_data[0] = gnt_tlb;

        prefer_tlb_d = prefer_tlb_q;
        if (gnt_l2)  prefer_tlb_d = 1'b1;
        if (gnt_tlb) prefer_tlb_d = 1'b0;

        ent0_d = ent0_q;
        ent1_d = ent1_q;
        if (pop) ent0_d = ent1_q;
        wr_idx = cnt_q - 2'(pop);
        if (push) begin
            if (wr_idx == 2'd0) ent0_d = push_data;
            else                ent1_d = push_data;
        end
        cnt_d = cnt_q - 2'(pop) + 2'(push);

        tlb_dec   = tlb_snack_valid && !tlb_snack_retry;
        tlb_out_d = tlb_out_q;
        if (gnt_tlb && !tlb_dec)
            tlb_out_d = tlb_out_q + 3'd1;
        else if (tlb_dec && !gnt_tlb && tlb_out_q != 3'd0)
            tlb_out_d = tlb_out_q - 3'd1;

        // Each destination blocks only snacks aimed at itself.
        snk_tgt    = drtol2_snack[0];
        l2s_drain  = l2s_v_q && !l2_snack_retry;
        tlbs_drain = tlbs_v_q && !tlb_snack_retry;
        drtol2_snack_retry = reset ||
            (snk_tgt ? (tlbs_v_q && !tlbs_drain) : (l2s_v_q && !l2s_drain));
        snk_acc = drtol2_snack_valid && !drtol2_snack_retry;

        l2s_v_d  = (l2s_v_q && !l2s_drain) || (snk_acc && !snk_tgt);
        l2s_d    = (snk_acc && !snk_tgt) ? drtol2_snack : l2s_q;
        tlbs_v_d = (tlbs_v_q && !tlbs_drain) || (snk_acc && snk_tgt);
        tlbs_d   = (snk_acc && snk_tgt) ? drtol2_snack : tlbs_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent0_q       <= '0;
            ent1_q       <= '0;
            cnt_q        <= '0;
            prefer_tlb_q <= 1'b0;
            tlb_out_q    <= '0;
            l2s_v_q      <= 1'b0;
            l2s_q        <= '0;
            tlbs_v_q     <= 1'b0;
            tlbs_q       <= '0;
        end else begin
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
            cnt_q        <= cnt_d;
            prefer_tlb_q <= prefer_tlb_d;
            tlb_out_q    <= tlb_out_d;
            l2s_v_q      <= l2s_v_d;
            l2s_q        <= l2s_d;
            tlbs_v_q     <= tlbs_v_d;
            tlbs_q       <= tlbs_d;
        end
    end

    assign l2_req_retry     = !gnt_l2;
    assign tlb_req_retry    = !gnt_tlb;
    assign l2todr_req_valid = (cnt_q != 2'd0);
    assign l2todr_req       = ent0_q;
    assign l2_snack_valid   = l2s_v_q;
    assign l2_snack         = l2s_q;
    assign tlb_snack_valid  = tlbs_v_q;
    assign tlb_snack        = tlbs_q;

endmodule

// File: tb/tb_l2dr_req_arb.sv
// Directed bench for l2dr_req_arb: stimulus pushes expected outputs into
// per-channel queues, a negedge monitor pops and compares on each transfer.
module tb_l2dr_req_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        l2_req_valid, l2_req_retry;
    logic [31:0] l2_req;
    logic        tlb_req_valid, tlb_req_retry;
    logic [31:0] tlb_req;
    logic        l2todr_req_valid, l2todr_req_retry;
    logic [31:0] l2todr_req;
    logic        drtol2_snack_valid, drtol2_snack_retry;
    logic [31:0] drtol2_snack;
    logic        l2_snack_valid, l2_snack_retry;
    logic [31:0] l2_snack;
    logic        tlb_snack_valid, tlb_snack_retry;
    logic [31:0] tlb_snack;

    int checks = 0;
    int passed = 0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_l2s[$];
    logic [31:0] exp_tlbs[$];

    l2dr_req_arb #(.TLB_MAX_OUT(2), .OUT_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .l2_req_valid(l2_req_valid), .l2_req_retry(l2_req_retry), .l2_req(l2_req),
        .tlb_req_valid(tlb_req_valid), .tlb_req_retry(tlb_req_retry), .tlb_req(tlb_req),
        .l2todr_req_valid(l2todr_req_valid), .l2todr_req_retry(l2todr_req_retry),
        .l2todr_req(l2todr_req),
        .drtol2_snack_valid(drtol2_snack_valid), .drtol2_snack_retry(drtol2_snack_retry),
        .drtol2_snack(drtol2_snack),
        .l2_snack_valid(l2_snack_valid), .l2_snack_retry(l2_snack_retry), .l2_snack(l2_snack),
        .tlb_snack_valid(tlb_snack_valid), .tlb_snack_retry(tlb_snack_retry),
        .tlb_snack(tlb_snack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Drive one cycle of source traffic, check retries, record expected outputs.
    task automatic cyc(input logic lv, input logic [31:0] ld,
                       input logic tv, input logic [31:0] td,
                       input logic sv, input logic [31:0] sd,
                       input logic e_lr, input logic e_tr, input logic e_sr);
        l2_req_valid = lv;  l2_req = ld;
        tlb_req_valid = tv; tlb_req = td;
        drtol2_snack_valid = sv; drtol2_snack = sd;
        #1;
        if (lv) begin
            chk("l2_req_retry", 32'(l2_req_retry), 32'(e_lr));
            if (!e_lr) exp_req.push_back({ld[31:1], 1'b0});
        end
        if (tv) begin
            chk("tlb_req_retry", 32'(tlb_req_retry), 32'(e_tr));
            if (!e_tr) exp_req.push_back({td[31:1], 1'b1});
        end
        if (sv) begin
            chk("drtol2_snack_retry", 32'(drtol2_snack_retry), 32'(e_sr));
            if (!e_sr) begin
                if (sd[0]) exp_tlbs.push_back(sd);
                else       exp_l2s.push_back(sd);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
    endtask

    always @(negedge clk) begin
        if (!reset && l2todr_req_valid && !l2todr_req_retry) begin
            if (exp_req.size() == 0) chk("l2todr_req_unexpected", 32'd1, 32'd0);
            else chk("l2todr_req", l2todr_req, exp_req.pop_front());
        end
        if (!reset && l2_snack_valid && !l2_snack_retry) begin
            if (exp_l2s.size() == 0) chk("l2_snack_unexpected", 32'd1, 32'd0);
            else chk("l2_snack", l2_snack, exp_l2s.pop_front());
        end
        if (!reset && tlb_snack_valid && !tlb_snack_retry) begin
            if (exp_tlbs.size() == 0) chk("tlb_snack_unexpected", 32'd1, 32'd0);
            else chk("tlb_snack", tlb_snack, exp_tlbs.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        l2_req_valid = 1'b1; l2_req = 32'h1111_0001;
        tlb_req_valid = 1'b1; tlb_req = 32'h2222_0000;
        drtol2_snack_valid = 1'b1; drtol2_snack = 32'h0;
        l2todr_req_retry = 1'b0; l2_snack_retry = 1'b0; tlb_snack_retry = 1'b0;
        @(posedge clk); #2;
        chk("rst_l2todr_valid", 32'(l2todr_req_valid), 0);
        chk("rst_l2_snack_valid", 32'(l2_snack_valid), 0);
        chk("rst_tlb_snack_valid", 32'(tlb_snack_valid), 0);
        chk("rst_l2_req_retry", 32'(l2_req_retry), 1);
        chk("rst_tlb_req_retry", 32'(tlb_req_retry), 1);
        chk("rst_snack_retry", 32'(drtol2_snack_retry), 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Round robin with both sources held valid: L2, TLB, L2, TLB.
        cyc(1, 32'hA000_0001, 1, 32'hB000_0000, 0, 0, 0, 1, 1);
        cyc(1, 32'hA001_0001, 1, 32'hB000_0000, 0, 0, 1, 0, 1);
        cyc(1, 32'hA001_0001, 1, 32'hB001_0000, 0, 0, 0, 1, 1);
        cyc(1, 32'hA002_0001, 1, 32'hB001_0000, 0, 0, 1, 0, 1);
        idle(2);

        // tlb_out=2: snack brings it to 1, then grant+snack in one cycle keeps it at 1.
        cyc(0, 0, 0, 0, 1, 32'h5000_0001, 1, 1, 0);
        cyc(0, 0, 1, 32'hB002_0000, 1, 32'h5001_0001, 1, 1, 0);
        cyc(0, 0, 1, 32'hB002_0000, 0, 0, 1, 0, 1);
        cyc(0, 0, 1, 32'hB003_0000, 0, 0, 1, 0, 1);
        // tlb_out=2: TLB retried until a snack frees a slot, then accepted next cycle.
        cyc(0, 0, 1, 32'hB004_0000, 1, 32'h5002_0001, 1, 1, 0);
        cyc(0, 0, 1, 32'hB004_0000, 0, 0, 1, 1, 1);
        cyc(0, 0, 1, 32'hB004_0000, 0, 0, 1, 0, 1);
        idle(2);

        // Directory back-pressure: third L2 request waits, then push+pop on full.
        l2todr_req_retry = 1'b1;
        cyc(1, 32'hA003_0001, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 32'hA004_0001, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 32'hA005_0001, 0, 0, 0, 0, 1, 1, 1);
        cyc(1, 32'hA005_0001, 0, 0, 0, 0, 1, 1, 1);
        chk("full_head_valid", 32'(l2todr_req_valid), 1);
        chk("full_head_data", l2todr_req, 32'hA003_0000);
        l2todr_req_retry = 1'b0;
        cyc(1, 32'hA005_0001, 0, 0, 0, 0, 0, 1, 1);
        idle(3);

        // Blocked L2 snack does not stall a TLB snack; reload on drain.
        l2_snack_retry = 1'b1;
        cyc(0, 0, 0, 0, 1, 32'h6000_0000, 1, 1, 0);
        cyc(0, 0, 0, 0, 1, 32'h6001_0000, 1, 1, 1);
        chk("l2_snack_held", 32'(l2_snack_valid), 1);
        cyc(0, 0, 0, 0, 1, 32'h6002_0001, 1, 1, 0);
        l2_snack_retry = 1'b0;
        cyc(0, 0, 0, 0, 1, 32'h6001_0000, 1, 1, 0);
        idle(2);

        // tlb_out is 1 here; fill FIFO to 2 and tlb_out to 2, then reset.
        l2todr_req_retry = 1'b1;
        cyc(0, 0, 1, 32'hB005_0000, 0, 0, 1, 0, 1);
        cyc(1, 32'hA006_0001, 0, 0, 0, 0, 0, 1, 1);
        l2_req_valid = 1'b1; tlb_req_valid = 1'b1; drtol2_snack_valid = 1'b1;
        reset = 1'b1;
        #1;
        chk("mid_rst_l2todr_valid", 32'(l2todr_req_valid), 0);
        chk("mid_rst_l2_snack_valid", 32'(l2_snack_valid), 0);
        chk("mid_rst_tlb_snack_valid", 32'(tlb_snack_valid), 0);
        chk("mid_rst_l2_req_retry", 32'(l2_req_retry), 1);
        chk("mid_rst_tlb_req_retry", 32'(tlb_req_retry), 1);
        exp_req.delete();
        exp_l2s.delete();
        exp_tlbs.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        l2todr_req_retry = 1'b0;
        cyc(1, 32'hA007_0001, 1, 32'hB006_0000, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 32'hB006_0000, 0, 0, 1, 0, 1);
        cyc(0, 0, 1, 32'hB007_0000, 0, 0, 1, 0, 1);
        idle(3);

        chk("req_queue_drained", 32'(exp_req.size()), 0);
        chk("l2_snack_queue_drained", 32'(exp_l2s.size()), 0);
        chk("tlb_snack_queue_drained", 32'(exp_tlbs.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
